// File: rtl/gp_cmd_fetch.sv
// GP command-list fetch front end: prefetches list words into a small FIFO and forwards them with the frame base.
// Optional stall counter on perf_stall is built when GP_FETCH_PERF_EN is defined.
module gp_cmd_fetch #(
  parameter int DEPTH     = 4,
  parameter int MAX_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] gp_code,
  input  logic [31:0] gp_frame,
  input  logic        gp_valid,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [31:0] cmd_data,
  output logic [31:0] cmd_frame,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] perf_stall
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(MAX_WORDS);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [AW:0]    OCC_ZERO = (AW+1)'(0);
  localparam logic [AW:0]    OCC_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
  localparam logic [AW+1:0]  CREDITS  = (AW+2)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  logic [31:0]   r_addr;
  logic [31:0]   r_frame;
  logic [31:0]   r_pend_code;
  logic [31:0]   r_pend_frame;
  logic          r_pend_valid;
  logic          r_stop_seen;
  logic          r_err_flag;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic [CW-1:0] r_cnt;
  logic [AW:0]   r_occ;
  logic [AW:0]   r_out;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [31:0]   r_fifo [DEPTH];

  logic [AW+1:0] w_inflight;
  logic          w_req_valid;
  logic          w_req_fire;
  logic          w_resp_take;
  logic          w_is_stop;
  logic          w_push;
  logic          w_stop_rx;
  logic          w_pop;
  logic          w_cnt_hit;
  logic          w_start;
  logic [31:0]   w_start_addr;
  logic [31:0]   w_start_frame;

  // Credit rule: buffered words plus reads in flight never exceed the FIFO depth.
  assign w_inflight   = {1'b0, r_occ} + {1'b0, r_out};
  assign w_req_valid  = (r_state == S_FETCH) && (w_inflight < CREDITS);
  assign w_req_fire   = w_req_valid && mem_req_ready;
  // A response with nothing outstanding is a leftover from before a reset.
  assign w_resp_take  = mem_resp_valid && (r_out != OCC_ZERO);
  assign w_is_stop    = (mem_resp_data[31:24] == 8'h00);
  assign w_push       = w_resp_take && !r_stop_seen && !w_is_stop;
  assign w_stop_rx    = w_resp_take && !r_stop_seen && w_is_stop;
  assign w_pop        = cmd_valid && cmd_ready;
  assign w_cnt_hit    = (r_cnt == (CNT_MAX - CNT_ONE));
  assign w_start      = ((r_state == S_IDLE) && gp_valid) ||
                        ((r_state == S_DONE) && (gp_valid || r_pend_valid));
  assign w_start_addr  = (gp_valid ? gp_code : r_pend_code) & 32'hFFFF_FFFC;
  assign w_start_frame = gp_valid ? gp_frame : r_pend_frame;

  assign mem_req_valid = w_req_valid;
  assign mem_req_addr  = r_addr;
  assign cmd_valid     = (r_occ != OCC_ZERO);
  assign cmd_data      = r_fifo[r_rptr];
  assign cmd_frame     = r_frame;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;

  // Prefetch FIFO storage, occupancy and outstanding-read count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_occ  <= OCC_ZERO;
      r_out  <= OCC_ZERO;
      r_wptr <= {AW{1'b0}};
      r_rptr <= {AW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo[i] <= 32'h0;
      end
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= mem_resp_data;
        r_wptr         <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_occ <= r_occ + OCC_ONE;
      end else if (!w_push && w_pop) begin
        r_occ <= r_occ - OCC_ONE;
      end
      if (w_req_fire && !w_resp_take) begin
        r_out <= r_out + OCC_ONE;
      end else if (!w_req_fire && w_resp_take) begin
        r_out <= r_out - OCC_ONE;
      end
    end
  end

  // Control FSM with registered status pulses and the single pending-kick slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_addr       <= 32'h0;
      r_frame      <= 32'h0;
      r_pend_code  <= 32'h0;
      r_pend_frame <= 32'h0;
      r_pend_valid <= 1'b0;
      r_stop_seen  <= 1'b0;
      r_err_flag   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_cnt        <= {CW{1'b0}};
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (gp_valid && (r_state != S_IDLE)) begin
        r_pend_valid <= 1'b1;
        r_pend_code  <= gp_code;
        r_pend_frame <= gp_frame;
      end
      // A STOP within the limit means the list ended cleanly, even if the limit was hit meanwhile.
      if (w_stop_rx) begin
        r_stop_seen <= 1'b1;
        r_err_flag  <= 1'b0;
      end
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start) begin
            r_state      <= S_FETCH;
            r_addr       <= w_start_addr;
            r_frame      <= w_start_frame;
            r_cnt        <= {CW{1'b0}};
            r_stop_seen  <= 1'b0;
            r_err_flag   <= 1'b0;
            r_busy       <= 1'b1;
            r_pend_valid <= 1'b0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_FETCH: begin
          if (w_req_fire) begin
            r_addr <= r_addr + 32'd4;
            r_cnt  <= r_cnt + CNT_ONE;
          end
          if (w_stop_rx) begin
            r_state <= S_DRAIN;
          end else if (w_req_fire && w_cnt_hit) begin
            r_state    <= S_DRAIN;
            r_err_flag <= 1'b1;
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_DRAIN: begin
          if ((r_occ == OCC_ZERO) && (r_out == OCC_ZERO)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= !r_err_flag;
            r_err   <= r_err_flag;
          end else begin
            r_state <= S_DRAIN;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef GP_FETCH_PERF_EN
  logic [31:0] r_perf;

  // Saturating count of cycles where the engine holds off a valid command word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf <= 32'h0;
    end else if (w_start) begin
      r_perf <= 32'h0;
    end else if (cmd_valid && !cmd_ready && (r_perf != 32'hFFFF_FFFF)) begin
      r_perf <= r_perf + 32'd1;
    end else begin
      r_perf <= r_perf;
    end
  end

  assign perf_stall = r_perf;
`else
  assign perf_stall = 32'h0;
`endif

endmodule

// File: tb/tb_gp_cmd_fetch.sv
// Directed bench for gp_cmd_fetch: default instance plus a MAX_WORDS=8 instance for the word-limit case.
`timescale 1ns/1ps
module tb_gp_cmd_fetch;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] gp_code, gp_frame;
  logic        gp_valid, gp_valid_b;
  logic        mem_req_ready, cmd_ready;

  logic        mem_req_valid, mem_resp_valid, cmd_valid, busy, done, err;
  logic [31:0] mem_req_addr, mem_resp_data, cmd_data, cmd_frame, perf_stall;
  logic        b_req_valid, b_resp_valid, b_cmd_valid, b_busy, b_done, b_err;
  logic [31:0] b_req_addr, b_resp_data, b_cmd_data, b_cmd_frame, b_perf;

  gp_cmd_fetch dut (
    .clk(clk), .rst(rst), .gp_code(gp_code), .gp_frame(gp_frame), .gp_valid(gp_valid),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_frame(cmd_frame),
    .busy(busy), .done(done), .err(err), .perf_stall(perf_stall)
  );

  gp_cmd_fetch #(.DEPTH(4), .MAX_WORDS(8)) dut_b (
    .clk(clk), .rst(rst), .gp_code(gp_code), .gp_frame(gp_frame), .gp_valid(gp_valid_b),
    .mem_req_valid(b_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(b_req_addr),
    .mem_resp_valid(b_resp_valid), .mem_resp_data(b_resp_data),
    .cmd_valid(b_cmd_valid), .cmd_ready(cmd_ready), .cmd_data(b_cmd_data), .cmd_frame(b_cmd_frame),
    .busy(b_busy), .done(b_done), .err(b_err), .perf_stall(b_perf)
  );

  // Shared memory image; each instance has its own 2-cycle in-order read pipeline.
  logic [31:0] mem [0:1023];
  logic        s1_v = 1'b0, s2_v = 1'b0, bs1_v = 1'b0, bs2_v = 1'b0;
  logic [31:0] s1_d = 32'h0, s2_d = 32'h0, bs1_d = 32'h0, bs2_d = 32'h0;

  always @(posedge clk) begin
    s1_v  <= mem_req_valid && mem_req_ready;
    s1_d  <= mem[mem_req_addr[11:2]];
    s2_v  <= s1_v;
    s2_d  <= s1_d;
    bs1_v <= b_req_valid && mem_req_ready;
    bs1_d <= mem[b_req_addr[11:2]];
    bs2_v <= bs1_v;
    bs2_d <= bs1_d;
  end
  assign mem_resp_valid = s2_v;
  assign mem_resp_data  = s2_d;
  assign b_resp_valid   = bs2_v;
  assign b_resp_data    = bs2_d;

  // Transaction monitors.
  logic [31:0] req_q[$], pop_q[$], frame_q[$], b_req_q[$], b_pop_q[$];
  int done_cnt = 0, err_cnt = 0, b_done_cnt = 0, b_err_cnt = 0;

  always @(posedge clk) begin
    if (mem_req_valid && mem_req_ready) req_q.push_back(mem_req_addr);
    if (cmd_valid && cmd_ready) begin
      pop_q.push_back(cmd_data);
      frame_q.push_back(cmd_frame);
    end
    if (b_req_valid && mem_req_ready) b_req_q.push_back(b_req_addr);
    if (b_cmd_valid && cmd_ready) b_pop_q.push_back(b_cmd_data);
    if (done) done_cnt <= done_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
    if (b_done) b_done_cnt <= b_done_cnt + 1;
    if (b_err) b_err_cnt <= b_err_cnt + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic kick(input logic [31:0] code, input logic [31:0] frame);
    @(negedge clk);
    gp_code  = code;
    gp_frame = frame;
    gp_valid = 1'b1;
    @(negedge clk);
    gp_valid = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget);
    int n;
    n = 0;
    while (!(done || err) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_end_seen"}, {31'b0, done | err}, 32'd1);
  endtask

  int base, pbase, dbase, n;
  logic [31:0] exp_perf;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0F00_0000 + 32'(i);
    mem[10'h040] = 32'h0100_0005; mem[10'h041] = 32'h0200_0007; mem[10'h042] = 32'h0000_0000;
    for (int i = 0; i < 10; i++) mem[10'h100 + i] = 32'h0A00_0000 + 32'(i);
    mem[10'h10A] = 32'h0000_0000;
    mem[10'h180] = 32'h0300_0001; mem[10'h181] = 32'h0000_0000;
    for (int i = 0; i < 12; i++) mem[10'h200 + i] = 32'h0400_0000 + 32'(i);
    mem[10'h280] = 32'h0500_0001; mem[10'h281] = 32'h0500_0002;
    mem[10'h282] = 32'h0500_0003; mem[10'h283] = 32'h0000_0000;
    mem[10'h080] = 32'h0600_0001; mem[10'h081] = 32'h0000_0000;

    rst = 1'b0; gp_code = 32'h0; gp_frame = 32'h0; gp_valid = 1'b0; gp_valid_b = 1'b0;
    mem_req_ready = 1'b1; cmd_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("rst_req_addr", mem_req_addr, 32'h0);
    chk("rst_cmd_valid", {31'b0, cmd_valid}, 32'd0);
    chk("rst_cmd_frame", cmd_frame, 32'h0);
    chk("rst_busy_done_err", {29'b0, busy, done, err}, 32'd0);
    chk("rst_perf", perf_stall, 32'h0);
    rst = 1'b1;

    // 1: basic three-word list with STOP at word 3.
    base = req_q.size(); pbase = pop_q.size();
    @(negedge clk);
    gp_code = 32'h1000_0102; gp_frame = 32'h1F80_0000; gp_valid = 1'b1;
    chk("t1_busy_at_kick", {31'b0, busy}, 32'd0);
    @(negedge clk);
    gp_valid = 1'b0;
    chk("t1_busy_after_kick", {31'b0, busy}, 32'd1);
    chk("t1_first_addr", mem_req_addr, 32'h1000_0100);
    wait_end("t1", 60);
    chk("t1_done_err_busy", {29'b0, done, err, busy}, 32'b100);
    @(negedge clk);
    chk("t1_after_pulse", {30'b0, busy, done}, 32'd0);
    chk("t1_done_count", 32'(done_cnt), 32'd1);
    chk("t1_req0", req_q[base], 32'h1000_0100);
    chk("t1_req1", req_q[base + 1], 32'h1000_0104);
    chk("t1_req2", req_q[base + 2], 32'h1000_0108);
    chk("t1_pop_count", 32'(pop_q.size() - pbase), 32'd2);
    chk("t1_word0", pop_q[pbase], 32'h0100_0005);
    chk("t1_word1", pop_q[pbase + 1], 32'h0200_0007);
    chk("t1_frame0", frame_q[pbase], 32'h1F80_0000);
    chk("t1_frame1", frame_q[pbase + 1], 32'h1F80_0000);

    // 2: ten-word list with the engine stalled for 20 cycles.
    cmd_ready = 1'b0;
    kick(32'h1000_0400, 32'h2F00_0000);
    base = req_q.size(); pbase = pop_q.size();
    n = 0;
    while (!cmd_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t2_cmd_valid_rise", {31'b0, cmd_valid}, 32'd1);
    repeat (20) @(negedge clk);
    chk("t2_credit_limit", 32'(req_q.size() - base), 32'd4);
    chk("t2_head_stable", cmd_data, 32'h0A00_0000);
    cmd_ready = 1'b1;
    wait_end("t2", 100);
`ifdef GP_FETCH_PERF_EN
    exp_perf = 32'd20;
`else
    exp_perf = 32'd0;
`endif
    chk("t2_perf_stall", perf_stall, exp_perf);
    chk("t2_pop_count", 32'(pop_q.size() - pbase), 32'd10);
    for (int i = 0; i < 10; i++) chk("t2_word", pop_q[pbase + i], 32'h0A00_0000 + 32'(i));

    // 3: STOP at word 2; words 3..4 are fetched and dropped.
    base = req_q.size(); pbase = pop_q.size();
    kick(32'h1000_0600, 32'h3300_0000);
    wait_end("t3", 60);
    chk("t3_done", {30'b0, done, err}, 32'b10);
    chk("t3_nothing_in_flight", {30'b0, s1_v, s2_v}, 32'd0);
    chk("t3_req_count", 32'(req_q.size() - base), 32'd4);
    chk("t3_req3", req_q[base + 3], 32'h1000_060C);
    chk("t3_pop_count", 32'(pop_q.size() - pbase), 32'd1);
    chk("t3_word0", pop_q[pbase], 32'h0300_0001);
    @(negedge clk);

    // 4: MAX_WORDS=8 instance with no STOP in the list.
    gp_code = 32'h1000_0800; gp_frame = 32'h4444_0000; gp_valid_b = 1'b1;
    @(negedge clk);
    gp_valid_b = 1'b0;
    n = 0;
    while (!(b_done || b_err) && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk("t4_err_pulse", {29'b0, b_err, b_done, b_busy}, 32'b100);
    @(negedge clk);
    chk("t4_req_count", 32'(b_req_q.size()), 32'd8);
    chk("t4_req7", b_req_q[7], 32'h1000_081C);
    chk("t4_pop_count", 32'(b_pop_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) chk("t4_word", b_pop_q[i], 32'h0400_0000 + 32'(i));
    chk("t4_done_count", 32'(b_done_cnt), 32'd0);
    chk("t4_err_count", 32'(b_err_cnt), 32'd1);

    // 5: second kick mid-list starts straight after done.
    pbase = pop_q.size(); dbase = done_cnt;
    kick(32'h1000_0A00, 32'h5555_0000);
    @(negedge clk);
    kick(32'h1000_0200, 32'h6666_0000);
    wait_end("t5a", 60);
    chk("t5_first_done", {30'b0, done, err}, 32'b10);
    @(negedge clk);
    chk("t5_no_gap_valid", {31'b0, mem_req_valid}, 32'd1);
    chk("t5_no_gap_addr", mem_req_addr, 32'h1000_0200);
    chk("t5_new_frame", cmd_frame, 32'h6666_0000);
    chk("t5_busy", {31'b0, busy}, 32'd1);
    wait_end("t5b", 60);
    @(negedge clk);
    chk("t5_done_count", 32'(done_cnt - dbase), 32'd2);
    chk("t5_pop_count", 32'(pop_q.size() - pbase), 32'd4);
    chk("t5_word2", pop_q[pbase + 2], 32'h0500_0003);
    chk("t5_frame2", frame_q[pbase + 2], 32'h5555_0000);
    chk("t5_word3", pop_q[pbase + 3], 32'h0600_0001);
    chk("t5_frame3", frame_q[pbase + 3], 32'h6666_0000);

    // 6: reset with two reads in flight, then a fresh list.
    kick(32'h1000_0C00, 32'h7777_0000);
    n = 0;
    while (!(s1_v && s2_v) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_two_outstanding", {30'b0, s1_v, s2_v}, 32'b11);
    rst = 1'b0;
    #1;
    chk("t6_rst_req", {31'b0, mem_req_valid}, 32'd0);
    chk("t6_rst_addr", mem_req_addr, 32'h0);
    chk("t6_rst_cmd", {31'b0, cmd_valid}, 32'd0);
    chk("t6_rst_data", cmd_data, 32'h0);
    chk("t6_rst_frame", cmd_frame, 32'h0);
    chk("t6_rst_flags", {29'b0, busy, done, err}, 32'd0);
    chk("t6_rst_perf", perf_stall, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_stray_ignored", {29'b0, cmd_valid, busy, mem_req_valid}, 32'd0);
    pbase = pop_q.size(); dbase = done_cnt;
    kick(32'h1000_0100, 32'h1F80_0000);
    wait_end("t6", 60);
    @(negedge clk);
    chk("t6_done_count", 32'(done_cnt - dbase), 32'd1);
    chk("t6_pop_count", 32'(pop_q.size() - pbase), 32'd2);
    chk("t6_word0", pop_q[pbase], 32'h0100_0005);
    chk("t6_word1", pop_q[pbase + 1], 32'h0200_0007);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
